// File: rtl/variable_chooser_if.sv
// Bus between the MCMC proposal stage and the variable chooser: enable/seed in,
// registered type/index choice out.
interface variable_chooser_if #(
   parameter int unsigned INDEX_WIDTH = 2
) ();
   logic                   in_enable;
   logic [7:0]             in_seed;
   logic                   out_boolean_or_integer;
   logic [INDEX_WIDTH-1:0] out_choosen_index;

   modport master (
      output in_enable,
      output in_seed,
      input  out_boolean_or_integer,
      input  out_choosen_index
   );

   modport slave (
      input  in_enable,
      input  in_seed,
      output out_boolean_or_integer,
      output out_choosen_index
   );
endinterface

// File: rtl/variable_chooser.sv
// Pseudo-random variable selector: an 8-bit maximal-length LFSR picks a variable type
// (boolean/integer) and an index reduced modulo that type's variable count.
module variable_chooser #(
   parameter int unsigned NUM_BOOLEAN_VARIABLES = 4,
   parameter int unsigned NUM_INTEGER_VARIABLES = 4,
   parameter int unsigned INDEX_WIDTH           = 2
) (
   input logic               in_clock,
   input logic               in_reset,
   variable_chooser_if.slave bus
);

   localparam int unsigned MaxCount = 1 << INDEX_WIDTH;
   // Zero counts are replaced by 1 only to keep the unused modulo branch well defined.
   localparam int unsigned BoolMod  = (NUM_BOOLEAN_VARIABLES == 0) ? 1 : NUM_BOOLEAN_VARIABLES;
   localparam int unsigned IntMod   = (NUM_INTEGER_VARIABLES == 0) ? 1 : NUM_INTEGER_VARIABLES;

   if (NUM_BOOLEAN_VARIABLES == 0 && NUM_INTEGER_VARIABLES == 0) begin : gen_err_no_vars
      $error("variable_chooser: both variable counts are zero");
   end
   if (NUM_BOOLEAN_VARIABLES > MaxCount || NUM_INTEGER_VARIABLES > MaxCount) begin : gen_err_width
      $error("variable_chooser: a variable count exceeds 2^INDEX_WIDTH");
   end

   logic [7:0]             lfsr_q, lfsr_d;
   logic                   type_q, type_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;

   logic                   feedback;
   logic [7:0]             lfsr_nxt;
   logic                   sel_type;
   logic [31:0]            low_bits;
   logic [INDEX_WIDTH-1:0] sel_index;

   // Choice is derived from the advanced LFSR value so outputs track lfsr_q after the edge.
   always_comb begin
      feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
      lfsr_nxt = {lfsr_q[6:0], feedback};

      if (NUM_BOOLEAN_VARIABLES == 0) begin
         sel_type = 1'b0;
      end else if (NUM_INTEGER_VARIABLES == 0) begin
         sel_type = 1'b1;
      end else begin
         sel_type = lfsr_nxt[7];
      end

      low_bits = {25'd0, lfsr_nxt[6:0]};
      if (sel_type) begin
         sel_index = INDEX_WIDTH'(low_bits % BoolMod);
      end else begin
         sel_index = INDEX_WIDTH'(low_bits % IntMod);
      end
   end

   always_comb begin
      lfsr_d  = lfsr_q;
      type_d  = type_q;
      index_d = index_q;
      if (in_reset) begin
         // A zero seed would lock the LFSR, so it is promoted to 1.
         lfsr_d  = (bus.in_seed == 8'h00) ? 8'h01 : bus.in_seed;
         type_d  = 1'b0;
         index_d = '0;
      end else if (bus.in_enable) begin
         lfsr_d  = lfsr_nxt;
         type_d  = sel_type;
         index_d = sel_index;
      end
   end

   always_ff @(posedge in_clock) begin
      lfsr_q  <= lfsr_d;
      type_q  <= type_d;
      index_q <= index_d;
   end

   assign bus.out_boolean_or_integer = type_q;
   assign bus.out_choosen_index      = index_q;

endmodule

// File: tb/tb_variable_chooser.sv
// Directed bench for variable_chooser: default 4/4/2 instance plus a 3/0/2 instance
// that must always choose boolean variables.
module tb_variable_chooser;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   variable_chooser_if #(.INDEX_WIDTH(2)) bus_a ();
   variable_chooser_if #(.INDEX_WIDTH(2)) bus_b ();

   variable_chooser #(
      .NUM_BOOLEAN_VARIABLES(4),
      .NUM_INTEGER_VARIABLES(4),
      .INDEX_WIDTH(2)
   ) dut (
      .in_clock(clk),
      .in_reset(rst),
      .bus(bus_a.slave)
   );

   variable_chooser #(
      .NUM_BOOLEAN_VARIABLES(3),
      .NUM_INTEGER_VARIABLES(0),
      .INDEX_WIDTH(2)
   ) dut_bool (
      .in_clock(clk),
      .in_reset(rst),
      .bus(bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   logic [7:0] exp_lfsr [5];
   logic [1:0] exp_idx  [5];

   initial begin
      logic [7:0] model;
      int         ones;
      int         zeros;
      int         bad_range;

      checks   = 0;
      failures = 0;
      exp_lfsr = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
      exp_idx  = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd3};

      // Seed load with enable high: reset must win on both edges.
      rst = 1'b1;
      bus_a.in_enable = 1'b1;
      bus_a.in_seed   = 8'h01;
      bus_b.in_enable = 1'b1;
      bus_b.in_seed   = 8'h01;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reset_lfsr", 32'(dut.lfsr_q), 32'h01);
         check("reset_type", 32'(bus_a.out_boolean_or_integer), 32'd0);
         check("reset_index", 32'(bus_a.out_choosen_index), 32'd0);
      end
      check("reset_b_type", 32'(bus_b.out_boolean_or_integer), 32'd0);

      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("seq_lfsr", 32'(dut.lfsr_q), 32'(exp_lfsr[i]));
         check("seq_type", 32'(bus_a.out_boolean_or_integer), 32'd0);
         check("seq_index", 32'(bus_a.out_choosen_index), 32'(exp_idx[i]));
      end

      bus_a.in_enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("hold_lfsr", 32'(dut.lfsr_q), 32'h23);
         check("hold_type", 32'(bus_a.out_boolean_or_integer), 32'd0);
         check("hold_index", 32'(bus_a.out_choosen_index), 32'd3);
      end
      bus_a.in_enable = 1'b1;
      tick();
      check("resume_lfsr", 32'(dut.lfsr_q), 32'h47);
      check("resume_type", 32'(bus_a.out_boolean_or_integer), 32'd0);
      check("resume_index", 32'(bus_a.out_choosen_index), 32'd3);

      // Zero seed is promoted to 1 and replays the seed=1 sequence.
      rst = 1'b1;
      bus_a.in_seed = 8'h00;
      bus_b.in_seed = 8'h00;
      tick();
      check("zseed_lfsr", 32'(dut.lfsr_q), 32'h01);
      check("zseed_type", 32'(bus_a.out_boolean_or_integer), 32'd0);
      check("zseed_index", 32'(bus_a.out_choosen_index), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("zseq_lfsr", 32'(dut.lfsr_q), 32'(exp_lfsr[i]));
         check("zseq_index", 32'(bus_a.out_choosen_index), 32'(exp_idx[i]));
      end

      // Full period from seed 1 on both instances.
      rst = 1'b1;
      bus_a.in_seed = 8'h01;
      bus_b.in_seed = 8'h01;
      tick();
      rst       = 1'b0;
      model     = 8'h01;
      ones      = 0;
      zeros     = 0;
      bad_range = 0;
      for (int i = 0; i < 255; i++) begin
         tick();
         model = lfsr_step(model);
         if (bus_a.out_boolean_or_integer === 1'b1) ones++;
         if (bus_a.out_boolean_or_integer === 1'b0) zeros++;
         if (bus_b.out_choosen_index > 2'd2) bad_range++;
         check("per_lfsr", 32'(dut.lfsr_q), 32'(model));
         check("per_type", 32'(bus_a.out_boolean_or_integer), 32'(model[7]));
         check("per_index", 32'(bus_a.out_choosen_index),
               model[7] ? 32'(model[6:0]) % 4 : 32'(model[6:0]) % 4);
         check("bool_type", 32'(bus_b.out_boolean_or_integer), 32'd1);
         check("bool_index", 32'(bus_b.out_choosen_index), 32'(model[6:0]) % 3);
      end
      check("period_wrap", 32'(dut.lfsr_q), 32'h01);
      check("period_bool_wrap", 32'(dut_bool.lfsr_q), 32'h01);
      check("type1_count", 32'(ones), 32'd128);
      check("type0_count", 32'(zeros), 32'd127);
      check("bool_range", 32'(bad_range), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
